spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 47 ++++
 rtl/spi_master.sv | 181 ++++++++++++++++++
 tb/tb_spi_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared SPI constants and types.
// Holds the word width, the spi_master FSM state encoding, and the
// constants used by the companion spi_slave block.
package spi_master_pkg;

  localparam int WORD_W    = 32;
  localparam int BIT_CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } master_state_t;

  // spi_slave constants
  typedef enum logic [1:0] {
    SLV_IDLE   = 2'd0,
    SLV_ACTIVE = 2'd1,
    SLV_DONE   = 2'd2
  } slave_state_t;

  localparam logic [WORD_W-1:0] SLAVE_RESET_WORD = '0;

endpackage

// File: rtl/spi_clk_div.sv
// SCK phase timer for spi_master.
// Counts CLK_DIV clk cycles per SCK half-period while enabled and strobes
// fall_tick / rise_tick on the cycle whose closing edge should move SCK.
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   en                counting enable (high only while shifting)
//   rise_tick         SCK should go high on this edge
//   fall_tick         SCK should go low on this edge
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             high_phase;
  logic             wrap;

  assign wrap = en && (cnt == CNT_W'(CLK_DIV - 1));

  // The master raises SCK itself when entering SHIFT, so the timer always
  // starts in the high half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      high_phase <= 1'b1;
    end else if (!en) begin
      cnt        <= '0;
      high_phase <= 1'b1;
    end else if (wrap) begin
      cnt        <= '0;
      high_phase <= !high_phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fall_tick = wrap && high_phase;
  assign rise_tick = wrap && !high_phase;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master with a one-word TX buffer and a one-word RX holding
// register.
// Ports:
//   clk, reset_n               system clock, async active-low reset
//   wr_en, wr_data             load a 32-bit word into the TX buffer
//   wr_buffer_free             TX buffer empty
//   rd_data                    last complete received word
//   rd_data_available, rd_ack  received-word flag and its acknowledge
//   rd_overrun                 one-cycle pulse when unacknowledged data is replaced
//   busy                       FSM is not in IDLE
//   SPI_SCK, SPI_SS, SPI_MOSI  master pins (SS active-low)
//   SPI_MISO                   slave data, sampled directly
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_buffer_free,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_data_available,
  input  logic              rd_ack,
  output logic              rd_overrun,
  output logic              busy,
  output logic              SPI_SCK,
  output logic              SPI_SS,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);

  localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  master_state_t state, next_state;

  logic [CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WORD_W-1:0]    buf_data;
  logic                 buf_full;
  logic [WORD_W-1:0]    shift_reg;
  logic [WORD_W-1:0]    rx_reg;
  logic                 sck_q;
  logic                 ss_q;

  logic rise_tick, fall_tick;
  logic load, first_rise, finish, sample_evt, fall_evt, advance;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (state == SHIFT),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // The SS-high interval between words is the GAP cycles plus the IDLE
  // cycle that launches the next word, so GAP itself runs SS_GAP-1 cycles.
  // The final rise_tick of SHIFT (after the last falling edge) is not an
  // SCK edge; it only marks the end of the last low half-period.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    first_rise = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          load       = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          first_rise = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_tick && (bit_cnt == BIT_CNT_W'(WORD_W))) next_state = HOLD;
      end
      HOLD: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          finish     = 1'b1;
          next_state = (SS_GAP > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(SS_GAP - 2)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign sample_evt = first_rise ||
                      ((state == SHIFT) && rise_tick && (bit_cnt != BIT_CNT_W'(WORD_W)));
  assign fall_evt   = (state == SHIFT) && fall_tick;
  assign advance    = fall_evt && (bit_cnt < BIT_CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if ((state == SETUP) || (state == HOLD) || (state == GAP)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (wr_en && !buf_full) begin
      buf_full <= 1'b1;
      buf_data <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      rx_reg    <= '0;
      bit_cnt   <= '0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      if (load) begin
        shift_reg <= buf_data;
        bit_cnt   <= '0;
        ss_q      <= 1'b0;
      end
      if (sample_evt) begin
        rx_reg <= {rx_reg[WORD_W-2:0], SPI_MISO};
        sck_q  <= 1'b1;
      end
      if (fall_evt) begin
        sck_q   <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (advance) shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      if (finish)  ss_q      <= 1'b1;
    end
  end

  // New data always replaces old; an acknowledge in the completion cycle
  // means the consumer took the old word, so no overrun is flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data           <= '0;
      rd_data_available <= 1'b0;
      rd_overrun        <= 1'b0;
    end else begin
      rd_overrun <= 1'b0;
      if (finish) begin
        rd_data           <= rx_reg;
        rd_data_available <= 1'b1;
        rd_overrun        <= rd_data_available && !rd_ack;
      end else if (rd_ack) begin
        rd_data_available <= 1'b0;
      end
    end
  end

  assign wr_buffer_free = !buf_full;
  assign busy           = (state != IDLE);
  assign SPI_SCK        = sck_q;
  assign SPI_SS         = ss_q;
  assign SPI_MOSI       = shift_reg[WORD_W-1];

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: behavioural mode-0 slave (loopback or
// echo-previous-word), scoreboard queues filled at stimulus time and
// drained by independent monitors.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int CLK_DIV     = 2;
  localparam int SS_GAP      = 4;
  localparam int WORD_CYCLES = CLK_DIV * (2 + 64);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_ack = 1'b0;
  logic        wr_buffer_free, rd_data_available, rd_overrun, busy;
  logic [31:0] rd_data;
  logic        SPI_SCK, SPI_SS, SPI_MOSI, SPI_MISO;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_q[$];
  logic [31:0] mosi_q[$];
  bit          loopback = 1'b1;
  logic [31:0] prev_model = '0;
  bit          ack_random = 1'b0;
  bit          ack_manual = 1'b0;

  logic [31:0] slv_tx = '0, slv_rx = '0, slv_last = '0;
  int          slv_bits = 0;
  logic        slv_miso = 1'b0;

  assign SPI_MISO = loopback ? SPI_MOSI : slv_miso;

  spi_master #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .wr_buffer_free    (wr_buffer_free),
    .rd_data           (rd_data),
    .rd_data_available (rd_data_available),
    .rd_ack            (rd_ack),
    .rd_overrun        (rd_overrun),
    .busy              (busy),
    .SPI_SCK           (SPI_SCK),
    .SPI_SS            (SPI_SS),
    .SPI_MOSI          (SPI_MOSI),
    .SPI_MISO          (SPI_MISO)
  );

  initial forever #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Write one word once the buffer is free; record what the slave should
  // see on MOSI and what the master should receive back.
  task automatic apply_stimulus(input logic [31:0] w);
    int n = 0;
    while (!wr_buffer_free && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (!wr_buffer_free) begin
      check_output("wr_buffer_free_timeout", {31'b0, wr_buffer_free}, 32'd1);
      return;
    end
    wr_data = w;
    wr_en   = 1'b1;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    rd_q.push_back(loopback ? w : prev_model);
    mosi_q.push_back(w);
    prev_model = w;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(wr_buffer_free && !busy) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check_output("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_ss_low();
    int n = 0;
    while (SPI_SS && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (SPI_SS) check_output("ss_fall_timeout", {31'b0, SPI_SS}, 32'd0);
  endtask

  task automatic pulse_ack();
    ack_manual = 1'b1;
    @(posedge clk); #1;
    ack_manual = 1'b0;
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #2;
    rd_ack = ack_manual | (ack_random & ($urandom_range(0, 3) == 0));
  end

  // Behavioural slave: loads its last fully received word at SS fall,
  // shifts out on SCK fall, captures MOSI on SCK rise.
  always @(negedge SPI_SS) begin
    slv_tx   = slv_last;
    slv_miso = slv_tx[31];
    slv_bits = 0;
  end

  always @(posedge SPI_SCK) begin
    if (!SPI_SS) begin
      slv_rx = {slv_rx[30:0], SPI_MOSI};
      slv_bits++;
    end
  end

  always @(negedge SPI_SCK) begin
    if (!SPI_SS) begin
      slv_tx   = {slv_tx[30:0], 1'b0};
      slv_miso = slv_tx[31];
    end
  end

  always @(posedge SPI_SS) begin
    if (reset_n === 1'b1) begin
      check_output("slave_bit_count", slv_bits, 32'd32);
      if (slv_bits == 32) begin
        slv_last = slv_rx;
        if (mosi_q.size() == 0) check_output("mosi_unexpected_word", slv_rx, 32'hxxxx_xxxx);
        else check_output("mosi_word", slv_rx, mosi_q.pop_front());
      end
    end
  end

  // Completion monitor with its own model of rd_data_available/overrun.
  logic prev_ss = 1'b1;
  int   low_cycles = 0;
  bit   exp_avail = 1'b0;
  bit   exp_ovr = 1'b0;
  bit   ack_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_avail  = 1'b0;
      ack_prev   = 1'b0;
      prev_ss    = 1'b1;
      low_cycles = 0;
    end else begin
      exp_ovr = 1'b0;
      if (SPI_SS && !prev_ss) begin
        exp_ovr   = exp_avail && !ack_prev;
        exp_avail = 1'b1;
        check_output("ss_low_cycles", low_cycles, WORD_CYCLES);
        if (rd_q.size() == 0) check_output("rd_unexpected_word", rd_data, 32'hxxxx_xxxx);
        else check_output("rd_data", rd_data, rd_q.pop_front());
        check_output("rd_avail_on_done", {31'b0, rd_data_available}, 32'd1);
        check_output("rd_overrun_on_done", {31'b0, rd_overrun}, {31'b0, exp_ovr});
      end else begin
        if (ack_prev) exp_avail = 1'b0;
        if (ack_prev || rd_overrun) begin
          check_output("rd_avail_after_ack", {31'b0, rd_data_available}, {31'b0, exp_avail});
          check_output("rd_overrun_idle", {31'b0, rd_overrun}, 32'd0);
        end
      end
      if (!SPI_SS && prev_ss)
        check_output("wr_buffer_free_after_start", {31'b0, wr_buffer_free}, 32'd1);
      low_cycles = SPI_SS ? 0 : low_cycles + 1;
      prev_ss    = SPI_SS;
      ack_prev   = rd_ack;
    end
  end

  initial begin
    logic [31:0] saved_prev;
    int n;

    repeat (3) @(posedge clk); #1;
    check_output("reset_ss",    {31'b0, SPI_SS},            32'd1);
    check_output("reset_sck",   {31'b0, SPI_SCK},           32'd0);
    check_output("reset_mosi",  {31'b0, SPI_MOSI},          32'd0);
    check_output("reset_free",  {31'b0, wr_buffer_free},    32'd1);
    check_output("reset_rd",    rd_data,                    32'd0);
    check_output("reset_avail", {31'b0, rd_data_available}, 32'd0);
    check_output("reset_ovr",   {31'b0, rd_overrun},        32'd0);
    check_output("reset_busy",  {31'b0, busy},              32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] loopback word");
    loopback = 1'b1;
    apply_stimulus(32'hA5A5_0F0F);
    wait_idle();
    pulse_ack();

    $display("[TB] back-to-back words");
    apply_stimulus(32'h0000_0001);
    apply_stimulus(32'hFFFF_FFFF);
    check_output("busy_during_word", {31'b0, busy}, 32'd1);
    n = 0;
    while (!SPI_SS && n < 400) begin @(posedge clk); #1; n++; end
    n = 0;
    while (SPI_SS && n < 100) begin n++; @(posedge clk); #1; end
    check_output("ss_gap_cycles", n, SS_GAP);
    wait_idle();
    pulse_ack();

    $display("[TB] dropped writes");
    apply_stimulus(32'h1234_5678);
    check_output("free_low_after_write", {31'b0, wr_buffer_free}, 32'd0);
    wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    apply_stimulus(32'h0BAD_F00D);
    wr_data = 32'hCAFE_CAFE; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle();

    $display("[TB] overrun and coincident ack");
    pulse_ack();
    apply_stimulus(32'h1111_2222);
    wait_idle();
    apply_stimulus(32'h3333_4444);
    wait_idle();
    apply_stimulus(32'h5555_6666);
    wait_ss_low();
    repeat (WORD_CYCLES - 1) @(posedge clk);
    #1; ack_manual = 1'b1;
    @(posedge clk); #1; ack_manual = 1'b0;
    wait_idle();
    pulse_ack();

    $display("[TB] reset mid-word");
    saved_prev = prev_model;
    apply_stimulus(32'h8765_4321);
    wait_ss_low();
    repeat (33 * CLK_DIV) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    check_output("abort_ss",    {31'b0, SPI_SS},            32'd1);
    check_output("abort_sck",   {31'b0, SPI_SCK},           32'd0);
    check_output("abort_busy",  {31'b0, busy},              32'd0);
    check_output("abort_free",  {31'b0, wr_buffer_free},    32'd1);
    check_output("abort_avail", {31'b0, rd_data_available}, 32'd0);
    rd_q.delete();
    mosi_q.delete();
    prev_model = saved_prev;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("abort_rd_data", rd_data, 32'd0);
    apply_stimulus(32'hF0E1_D2C3);
    wait_idle();
    pulse_ack();

    $display("[TB] random words against echo slave");
    loopback   = 1'b0;
    ack_random = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      apply_stimulus($urandom);
    end
    wait_idle();
    ack_random = 1'b0;

    n = 0;
    while ((rd_q.size() != 0 || mosi_q.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check_output("rd_queue_drained",   rd_q.size(),   32'd0);
    check_output("mosi_queue_drained", mosi_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
